sseg_scan_driver: RTL and testbench

//  Time-multiplexed 8-digit seven-segment driver for the alarm clock top level.

---
 rtl/sseg_scan_driver.sv | 119 +++++++++++
 tb/tb_sseg_scan_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame input snapshot,
// per-digit blanking/blinking and active-low registered anode/cathode outputs.
module sseg_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DP,
  input  logic [7:0]  BLANK_MASK,
  input  logic [7:0]  BLINK_MASK,
  input  logic        BLINK_EN,
  output logic [7:0]  SSEG_AN,
  output logic [7:0]  SSEG_CA,
  output logic        FRAME
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0] pre;
  logic [2:0]       idx;
  logic [FC_W-1:0]  frame_cnt;
  logic             phase;

  logic [7:0][3:0]  snap_digits;
  logic [7:0]       snap_dp;
  logic [7:0]       snap_blank;
  logic [7:0]       snap_blink;
  logic             snap_blink_en;

  logic             tick;
  logic             load;
  logic [3:0]       cur_nib;
  logic             digit_off;

  // Segment pattern {g,f,e,d,c,b,a}, 1 = lit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h00;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    tick      = (pre == PRE_LAST);
    load      = tick && (idx == 3'd7);
    cur_nib   = snap_digits[idx];
    digit_off = snap_blank[idx] | (snap_blink_en & snap_blink[idx] & phase);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pre           <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      phase         <= 1'b0;
      // NOTE: the snapshot is reset (blank = all ones) so the first frame after reset is dark.
      snap_digits   <= '0;
      snap_dp       <= '0;
      snap_blank    <= 8'hFF;
      snap_blink    <= '0;
      snap_blink_en <= 1'b0;
      SSEG_AN       <= 8'hFF;
      SSEG_CA       <= 8'hFF;
      FRAME         <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= idx + 3'd1;
      FRAME <= load;

      // Inputs are captured only at the frame boundary so the display never tears.
      if (load) begin
        snap_digits   <= DIGITS;
        snap_dp       <= DP;
        snap_blank    <= BLANK_MASK;
        snap_blink    <= BLINK_MASK;
        snap_blink_en <= BLINK_EN;
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      if (digit_off) begin
        SSEG_AN <= 8'hFF;
        SSEG_CA <= 8'hFF;
      end else begin
        SSEG_AN <= ~(8'b1 << idx);
        SSEG_CA <= {~snap_dp[idx], ~seg7(cur_nib)};
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: directed scenarios plus randomized frames checked
// against a slot/frame arithmetic model of the display.
module tb_sseg_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 8 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] DIGITS;
  logic [7:0]  DP;
  logic [7:0]  BLANK_MASK;
  logic [7:0]  BLINK_MASK;
  logic        BLINK_EN;
  logic [7:0]  SSEG_AN;
  logic [7:0]  SSEG_CA;
  logic        FRAME;

  sseg_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .DIGITS    (DIGITS),
    .DP        (DP),
    .BLANK_MASK(BLANK_MASK),
    .BLINK_MASK(BLINK_MASK),
    .BLINK_EN  (BLINK_EN),
    .SSEG_AN   (SSEG_AN),
    .SSEG_CA   (SSEG_CA),
    .FRAME     (FRAME)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;
  int n;  // rising edges since the last reset release

  // Model view: the inputs the display is currently showing (captured each frame boundary).
  logic [31:0] m_digits;
  logic [7:0]  m_dp, m_blank, m_blink;
  logic        m_en;
  logic [6:0]  seg_lut [16];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    m_digits = '0;
    m_dp     = '0;
    m_blank  = 8'hFF;
    m_blink  = '0;
    m_en     = 1'b0;
  endtask

  // One clock: predict the registered outputs of this edge, then compare at the falling edge.
  task automatic step();
    int d, f;
    logic phase, off;
    logic [3:0] nib;
    logic [7:0] exp_an, exp_ca, exp_fr;
    @(posedge CLK);
    n++;
    d     = ((n - 1) / SCAN_DIV) % 8;
    f     = (n - 1) / FRAME_LEN;
    phase = ((f / BLINK_FRAMES) % 2) == 1;
    nib   = m_digits[d*4 +: 4];
    off   = m_blank[d] | (m_en & m_blink[d] & phase);
    exp_an = off ? 8'hFF : ~(8'h01 << d);
    exp_ca = off ? 8'hFF : {~m_dp[d], ~seg_lut[nib]};
    exp_fr = {7'b0, (n % FRAME_LEN) == 0};
    if ((n % FRAME_LEN) == 0) begin
      m_digits = DIGITS;
      m_dp     = DP;
      m_blank  = BLANK_MASK;
      m_blink  = BLINK_MASK;
      m_en     = BLINK_EN;
    end
    @(negedge CLK);
    check($sformatf("an@%0d", n), SSEG_AN, exp_an);
    check($sformatf("ca@%0d", n), SSEG_CA, exp_ca);
    check($sformatf("frame@%0d", n), {7'b0, FRAME}, exp_fr);
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Advance until the scan index has just become i (bounded by one frame).
  task automatic run_to_idx(input int i);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (((n / SCAN_DIV) % 8) != i && guard < 2 * FRAME_LEN);
  endtask

  task automatic set_inputs(input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] bl,
                            input logic [7:0] bk, input logic en);
    DIGITS     = dg;
    DP         = dp;
    BLANK_MASK = bl;
    BLINK_MASK = bk;
    BLINK_EN   = en;
  endtask

  initial begin
    seg_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset with a live digit word on the inputs.
    RSTN = 1'b1;
    set_inputs(32'h1234_5678, 8'h00, 8'h00, 8'h00, 1'b0);
    #2 RSTN = 1'b0;
    model_reset();
    @(negedge CLK);
    check("rst_an", SSEG_AN, 8'hFF);
    check("rst_ca", SSEG_CA, 8'hFF);
    check("rst_frame", {7'b0, FRAME}, 8'h00);
    @(negedge CLK);
    RSTN = 1'b1;

    // Dark first frame, then decode of 12345678.
    run(2 * FRAME_LEN);

    // Decimal point on digit 2, digit 7 blanked.
    set_inputs(32'h1234_5678, 8'h04, 8'h80, 8'h00, 1'b0);
    run(2 * FRAME_LEN);

    // Mid-frame change of the digit word while idx = 3.
    set_inputs(32'h1234_5678, 8'h00, 8'h00, 8'h00, 1'b0);
    run(FRAME_LEN);
    run_to_idx(3);
    DIGITS = 32'h0;
    run(2 * FRAME_LEN);

    // Blink digits 0 and 1.
    set_inputs(32'h1234_5678, 8'h00, 8'h00, 8'h03, 1'b1);
    run(6 * FRAME_LEN);

    // Randomized frames with inputs changing at random points inside the frame.
    for (int fr = 0; fr < 10; fr++) begin
      int k;
      k = int'($urandom_range(1, FRAME_LEN - 1));
      run(k);
      set_inputs($urandom, 8'($urandom), 8'($urandom) & 8'($urandom),
                 8'($urandom), 1'($urandom));
      run(FRAME_LEN - k);
    end

    // Asynchronous reset while idx = 5, with every digit lit.
    set_inputs($urandom, 8'($urandom), 8'h00, 8'h00, 1'b0);
    run(2 * FRAME_LEN);
    run_to_idx(5);
    #2 RSTN = 1'b0;
    #1;
    check("midrst_an", SSEG_AN, 8'hFF);
    check("midrst_ca", SSEG_CA, 8'hFF);
    check("midrst_frame", {7'b0, FRAME}, 8'h00);
    model_reset();
    set_inputs(32'h1234_5678, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    run(2 * FRAME_LEN + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
